mem_bus_responder: RTL

//  Synthesizable memory-side responder for the CPU word bus (addr/data/cs/we/oe).
//  - Replaces the behavioural RAM as the target of CPU fetch, load and store.
//  - Adds a one-cycle ack, a busy flag and a configurable read latency, so the CPU

---
 rtl/mem_bus_pkg.sv | 46 ++++
 rtl/mem_array.sv | 36 +++
 rtl/mem_bus_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types, widths and request decode for the CPU word-bus
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    localparam int CPU_ADDR_WIDTH = 14;
    localparam int CPU_DATA_WIDTH = 32;
    localparam int STATE_W        = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        WR_ACK   = 2'd1,
        RD_WAIT  = 2'd2,
        RD_DRIVE = 2'd3
    } resp_state_e;

    typedef enum logic [1:0] {
        REQ_NOP     = 2'd0,
        REQ_RD      = 2'd1,
        REQ_WR      = 2'd2,
        REQ_ILLEGAL = 2'd3
    } req_e;

    function automatic req_e decode_req(input logic cs, input logic we, input logic oe);
        req_e r;
        if (!cs)
            r = REQ_NOP;
        else if (we && oe)
            r = REQ_ILLEGAL;
        else if (we)
            r = REQ_WR;
        else if (oe)
            r = REQ_RD;
        else
            r = REQ_NOP;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module      : mem_array
// Description : Single-port synchronous word storage with a registered read
//               snapshot; no handshake logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array #(
    parameter int ADDR_WIDTH = 14,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [WIDTH-1:0] r_rdata;

    // Contents are deliberately left unreset; only the snapshot register feeds the bus.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module      : mem_bus_responder
// Description : Memory-side responder for the CPU word bus with ack/busy
//               handshake and READ_LAT-cycle read latency.
//               Optional feature macro: MEM_PARITY_EN (stored even parity).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    output logic                  ack,
    output logic                  busy,
    output logic                  err,
    output logic                  par_err
);

    generate
        if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_lat
            $fatal(1, "mem_bus_responder: READ_LAT must be in 1..7");
        end
    endgenerate

`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam int            CNT_W      = 3;
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(READ_LAT - 1);

    resp_state_e      r_state;
    resp_state_e      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    req_e             w_req;
    logic             w_idle;
    logic             w_wr;
    logic             w_rd;
    logic             w_drive;
    logic [MEM_W-1:0] w_wdata;
    logic [MEM_W-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_rd_q;

    assign w_req  = decode_req(cs, we, oe);
    assign w_idle = (r_state == IDLE);
    assign w_wr   = w_idle && (w_req == REQ_WR);
    assign w_rd   = w_idle && (w_req == REQ_RD);

`ifdef MEM_PARITY_EN
    assign w_wdata = {^data, data};
`else
    assign w_wdata = data;
`endif

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (MEM_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_re    (w_rd),
        .i_addr  (addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_rd_q = w_rdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_idle && (w_req == REQ_ILLEGAL);
            if (w_rd)
                r_cnt <= C_CNT_INIT;
            else if (r_state == RD_WAIT)
                r_cnt <= r_cnt - 3'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr)
                    w_next = WR_ACK;
                else if (w_rd)
                    w_next = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;
            end
            WR_ACK:   w_next = IDLE;
            RD_WAIT: begin
                // Dropping cs mid-read abandons it without an ack.
                if (!cs)
                    w_next = IDLE;
                else if (r_cnt == 3'd1)
                    w_next = RD_DRIVE;
            end
            RD_DRIVE: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        ack     = 1'b0;
        busy    = 1'b0;
        par_err = 1'b0;
        case (r_state)
            WR_ACK: begin
                ack  = 1'b1;
                busy = 1'b1;
            end
            RD_WAIT: busy = 1'b1;
            RD_DRIVE: begin
                ack  = 1'b1;
                busy = 1'b1;
`ifdef MEM_PARITY_EN
                par_err = ^w_rdata;
`endif
            end
            default: ;
        endcase
    end

    assign err = r_err;

    // Release follows oe combinationally so the bus frees the same cycle oe falls.
    assign w_drive = (r_state == RD_DRIVE) && oe;
    assign data    = w_drive ? w_rd_q : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire
